hs_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one valid/ready/response handshake slave among N_REQ masters. Each master presents valid plus a 32-bit data word. The arbiter grants one master at a time and forwards its valid/data to the slave. It routes the slave's ready and response back to the granted master only, and holds the grant until the response arrives or a watchdog expires. It sits between the master instances and the single slave instance on the handshake bus.

---
 rtl/hs_pkg.sv | 18 +
 rtl/hs_rr_pick.sv | 27 ++
 rtl/hs_rr_arbiter.sv | 103 ++++++++++
 tb/tb_hs_rr_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/hs_pkg.sv
// Shared handshake definitions: the state encoding used by the arbiter and by
// the master/slave handshake FSMs, plus the default bus data width.
package hs_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01,
        RESP  = 2'b11
    } hs_state_t;

    localparam int DW_DEFAULT = 32;

    // Modulo-n increment used for the round-robin pointer.
    function automatic int rr_next(input int g, input int n);
        return (g + 1 >= n) ? 0 : g + 1;
    endfunction

endpackage

// File: rtl/hs_rr_pick.sv
// Rotating-priority picker: returns the first set request at or after ptr,
// wrapping modulo N_REQ.
module hs_rr_pick #(
    parameter  int N_REQ = 4,
    localparam int GW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [GW-1:0]    ptr,
    output logic [GW-1:0]    idx,
    output logic             found
);

    always_comb begin
        int s;
        s     = 0;
        idx   = '0;
        found = |req;
        // Scan from the far end back toward ptr so the closest hit wins.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            s = (int'(ptr) + k) % N_REQ;
            if (req[s]) begin
                idx = GW'(s);
            end
        end
    end

endmodule

// File: rtl/hs_rr_arbiter.sv
// Round-robin arbiter sharing one valid/ready/response slave among N_REQ
// masters; the grant is held until the response arrives or the watchdog fires.
module hs_rr_arbiter
    import hs_pkg::*;
#(
    parameter  int N_REQ        = 4,
    parameter  int DW           = DW_DEFAULT,
    parameter  int RESP_TIMEOUT = 16,
    localparam int GW           = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int CW           = $clog2(RESP_TIMEOUT) + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_REQ-1:0]    m_valid,
    input  logic [N_REQ*DW-1:0] m_data,
    output logic [N_REQ-1:0]    m_ready,
    output logic [N_REQ-1:0]    m_response,
    output logic                s_valid,
    output logic [DW-1:0]       s_data,
    input  logic                s_ready,
    input  logic                s_response,
    output logic [GW-1:0]       grant_id,
    output logic                busy,
    output logic                timeout_err
);

    hs_state_t     state;
    logic [GW-1:0] ptr;
    logic [CW-1:0] cnt;
    logic [GW-1:0] pick_idx;
    logic          pick_found;
    logic          wd_expired;

    hs_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req   (m_valid),
        .ptr   (ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign wd_expired = (cnt == CW'(RESP_TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            grant_id <= '0;
            ptr      <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant_id <= pick_idx;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (!m_valid[grant_id]) begin
                        state <= IDLE;
                    end else if (s_ready) begin
                        state <= RESP;
                        cnt   <= '0;
                    end
                end
                RESP: begin
                    // A response coinciding with watchdog expiry is a normal completion.
                    if (s_response || wd_expired) begin
                        state <= IDLE;
                        ptr   <= GW'(rr_next(int'(grant_id), N_REQ));
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        m_ready     = '0;
        m_response  = '0;
        s_valid     = 1'b0;
        s_data      = '0;
        timeout_err = 1'b0;
        case (state)
            GRANT: begin
                s_valid           = m_valid[grant_id];
                s_data            = m_data[int'(grant_id)*DW +: DW];
                m_ready[grant_id] = s_ready;
            end
            RESP: begin
                m_response[grant_id] = s_response;
                timeout_err          = !s_response && wd_expired;
            end
            default: ;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_hs_rr_arbiter.sv
// Directed bench for hs_rr_arbiter with four masters and a 16-cycle watchdog.
module tb_hs_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  m_valid;
    logic [N*DW-1:0] m_data;
    logic [N-1:0]  m_ready;
    logic [N-1:0]  m_response;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic          s_response;
    logic [1:0]    grant_id;
    logic          busy;
    logic          timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    hs_rr_arbiter #(.N_REQ(N), .DW(DW), .RESP_TIMEOUT(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .m_valid     (m_valid),
        .m_data      (m_data),
        .m_ready     (m_ready),
        .m_response  (m_response),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .s_response  (s_response),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset      = 1'b0;
        m_valid    = '0;
        s_ready    = 1'b0;
        s_response = 1'b0;
        for (int i = 0; i < N; i++) m_data[i*DW +: DW] = 32'h1000_0000 + i;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        m_valid = 4'b1111;
        s_ready = 1'b1;
        s_response = 1'b1;
        #3;
        n_checks++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL reset_s_valid: got %b expected 0", s_valid); end
        n_checks++; if (s_data !== 32'h0) begin n_fail++; $display("FAIL reset_s_data: got %h expected 0", s_data); end
        n_checks++; if (m_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_m_ready: got %b expected 0000", m_ready); end
        n_checks++; if (m_response !== 4'b0000) begin n_fail++; $display("FAIL reset_m_response: got %b expected 0000", m_response); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b expected 0", timeout_err); end
        n_checks++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_grant_id: got %0d expected 0", grant_id); end
        apply_reset();
    endtask

    task automatic test_single();
        apply_reset();
        m_data[0 +: DW] = 32'hA5A5_0001;
        m_valid = 4'b0001;
        s_ready = 1'b1;
        #1;
        n_checks++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL single_idle_s_valid: got %b expected 0", s_valid); end
        tick();
        n_checks++; if (s_valid !== 1'b1) begin n_fail++; $display("FAIL single_s_valid: got %b expected 1", s_valid); end
        n_checks++; if (s_data !== 32'hA5A5_0001) begin n_fail++; $display("FAIL single_s_data: got %h expected a5a50001", s_data); end
        n_checks++; if (m_ready !== 4'b0001) begin n_fail++; $display("FAIL single_m_ready: got %b expected 0001", m_ready); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b expected 1", busy); end
        tick();
        m_valid = 4'b0000;
        #1;
        n_checks++; if (m_ready !== 4'b0000) begin n_fail++; $display("FAIL single_resp_m_ready: got %b expected 0000", m_ready); end
        n_checks++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL single_resp_s_valid: got %b expected 0", s_valid); end
        s_response = 1'b1;
        #1;
        n_checks++; if (m_response !== 4'b0001) begin n_fail++; $display("FAIL single_m_response: got %b expected 0001", m_response); end
        tick();
        s_response = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_back_idle: got %b expected 0", busy); end
        n_checks++; if (m_response !== 4'b0000) begin n_fail++; $display("FAIL single_resp_pulse: got %b expected 0000", m_response); end
        // pointer now at 1: with every master requesting, master 1 wins
        m_valid = 4'b1111;
        s_ready = 1'b0;
        tick();
        n_checks++; if (grant_id !== 2'd1) begin n_fail++; $display("FAIL single_ptr: got %0d expected 1", grant_id); end
    endtask

    task automatic test_round_robin();
        int exp_order[5] = '{0, 1, 2, 3, 0};
        apply_reset();
        m_valid    = 4'b1111;
        s_ready    = 1'b1;
        s_response = 1'b1;
        for (int g = 0; g < 5; g++) begin
            #1;
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rr_idle_%0d: busy got %b expected 0", g, busy); end
            tick();
            n_checks++; if (grant_id !== 2'(exp_order[g])) begin n_fail++; $display("FAIL rr_grant_%0d: got %0d expected %0d", g, grant_id, exp_order[g]); end
            n_checks++; if (s_data !== 32'h1000_0000 + exp_order[g]) begin n_fail++; $display("FAIL rr_data_%0d: got %h expected %h", g, s_data, 32'h1000_0000 + exp_order[g]); end
            n_checks++; if (m_ready !== 4'(1 << exp_order[g])) begin n_fail++; $display("FAIL rr_ready_%0d: got %b expected %b", g, m_ready, 4'(1 << exp_order[g])); end
            n_checks++; if (m_response !== 4'b0000) begin n_fail++; $display("FAIL rr_grant_resp_%0d: got %b expected 0000", g, m_response); end
            tick();
            n_checks++; if (m_response !== 4'(1 << exp_order[g])) begin n_fail++; $display("FAIL rr_resp_%0d: got %b expected %b", g, m_response, 4'(1 << exp_order[g])); end
            tick();
        end
    endtask

    task automatic test_ready_stall();
        apply_reset();
        m_data[1*DW +: DW] = 32'hBEEF_0011;
        m_valid    = 4'b0010;
        s_response = 1'b1;
        tick();
        for (int c = 0; c < 5; c++) begin
            n_checks++; if (s_valid !== 1'b1) begin n_fail++; $display("FAIL stall_s_valid_%0d: got %b expected 1", c, s_valid); end
            n_checks++; if (s_data !== 32'hBEEF_0011) begin n_fail++; $display("FAIL stall_s_data_%0d: got %h expected beef0011", c, s_data); end
            n_checks++; if (m_ready !== 4'b0000) begin n_fail++; $display("FAIL stall_m_ready_%0d: got %b expected 0000", c, m_ready); end
            n_checks++; if (m_response !== 4'b0000) begin n_fail++; $display("FAIL stall_m_resp_%0d: got %b expected 0000", c, m_response); end
            n_checks++; if (grant_id !== 2'd1) begin n_fail++; $display("FAIL stall_grant_%0d: got %0d expected 1", c, grant_id); end
            tick();
        end
        s_response = 1'b0;
        s_ready    = 1'b1;
        #1;
        n_checks++; if (m_ready !== 4'b0010) begin n_fail++; $display("FAIL stall_release_ready: got %b expected 0010", m_ready); end
        tick();
        n_checks++; if (s_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL stall_in_resp: s_valid %b busy %b expected 0 1", s_valid, busy); end
    endtask

    task automatic test_timeout();
        apply_reset();
        m_valid = 4'b0100;
        s_ready = 1'b1;
        tick();
        tick();
        m_valid = 4'b0000;
        for (int k = 0; k < 16; k++) begin
            #1;
            n_checks++; if (timeout_err !== (k == 15)) begin n_fail++; $display("FAIL to_pulse_%0d: got %b expected %b", k, timeout_err, (k == 15)); end
            n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL to_busy_%0d: got %b expected 1", k, busy); end
            tick();
        end
        n_checks++; if (busy !== 1'b0 || timeout_err !== 1'b0) begin n_fail++; $display("FAIL to_idle: busy %b timeout %b expected 0 0", busy, timeout_err); end
        m_valid = 4'b1111;
        s_ready = 1'b0;
        tick();
        n_checks++; if (grant_id !== 2'd3) begin n_fail++; $display("FAIL to_ptr: got %0d expected 3", grant_id); end

        // response on the expiry cycle is a completion, not an abort
        apply_reset();
        m_valid = 4'b0001;
        s_ready = 1'b1;
        tick();
        tick();
        m_valid = 4'b0000;
        repeat (15) tick();
        s_response = 1'b1;
        #1;
        n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL to_race_err: got %b expected 0", timeout_err); end
        n_checks++; if (m_response !== 4'b0001) begin n_fail++; $display("FAIL to_race_resp: got %b expected 0001", m_response); end
        tick();
        s_response = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL to_race_idle: got %b expected 0", busy); end
    endtask

    task automatic test_withdraw();
        apply_reset();
        m_valid = 4'b0100;
        tick();
        n_checks++; if (grant_id !== 2'd2 || s_valid !== 1'b1) begin n_fail++; $display("FAIL wd_grant: grant %0d s_valid %b expected 2 1", grant_id, s_valid); end
        m_valid = 4'b0000;
        #1;
        n_checks++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL wd_s_valid: got %b expected 0", s_valid); end
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wd_idle: got %b expected 0", busy); end
        // pointer stayed at 0, so master 2 beats master 3
        m_valid = 4'b1100;
        tick();
        n_checks++; if (grant_id !== 2'd2) begin n_fail++; $display("FAIL wd_regrant: got %0d expected 2", grant_id); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        m_valid = 4'b1000;
        s_ready = 1'b1;
        tick();
        tick();
        s_response = 1'b1;
        #2 reset = 1'b0;
        #1;
        n_checks++; if (m_response !== 4'b0000) begin n_fail++; $display("FAIL rmid_resp: got %b expected 0000", m_response); end
        n_checks++; if (busy !== 1'b0 || grant_id !== 2'd0) begin n_fail++; $display("FAIL rmid_state: busy %b grant %0d expected 0 0", busy, grant_id); end
        n_checks++; if (s_valid !== 1'b0 || m_ready !== 4'b0000) begin n_fail++; $display("FAIL rmid_outs: s_valid %b m_ready %b expected 0 0000", s_valid, m_ready); end
        @(posedge clk);
        #1 reset = 1'b1;
        s_response = 1'b0;
        m_valid    = 4'b1111;
        s_ready    = 1'b0;
        tick();
        n_checks++; if (grant_id !== 2'd0 || busy !== 1'b1) begin n_fail++; $display("FAIL rmid_restart: grant %0d busy %b expected 0 1", grant_id, busy); end
    endtask

    initial begin
        m_valid    = '0;
        m_data     = '0;
        s_ready    = 1'b0;
        s_response = 1'b0;
        reset      = 1'b1;
        #1;
        test_reset();
        test_single();
        test_round_robin();
        test_ready_stall();
        test_timeout();
        test_withdraw();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
